fb_swap_ctrl: RTL and testbench

FB_SWAP_CTRL -- requirements
Module: fb_swap_ctrl

---
 rtl/fb_pkg.sv | 37 +++
 rtl/fb_addr_gen.sv | 35 +++
 rtl/fb_swap_ctrl.sv | 116 +++++++++++
 tb/tb_fb_swap_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared constants, state enum and byte decoder for the framebuffer swap controller.
// Optional drop counter in fb_swap_ctrl is enabled by defining FB_DROP_COUNT_EN.
`timescale 1ns/1ps

package fb_pkg;

    localparam logic [7:0] CMD_ALIGN = 8'h80;
    localparam logic [7:0] CMD_SWAP  = 8'h81;
    localparam int         PIXEL_W   = 6;

    typedef enum logic {
        STREAM    = 1'b0,
        SWAP_WAIT = 1'b1
    } fb_state_t;

    typedef enum logic [1:0] {
        BYTE_PIXEL = 2'd0,
        BYTE_ALIGN = 2'd1,
        BYTE_SWAP  = 2'd2,
        BYTE_OTHER = 2'd3
    } byte_kind_t;

    // Bit 7 clear is always pixel data; only two of the bit-7-set codes mean anything.
    function automatic byte_kind_t decode_byte(input logic [7:0] b);
        byte_kind_t kind;
        if (!b[7])
            kind = BYTE_PIXEL;
        else if (b == CMD_ALIGN)
            kind = BYTE_ALIGN;
        else if (b == CMD_SWAP)
            kind = BYTE_SWAP;
        else
            kind = BYTE_OTHER;
        return kind;
    endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Framebuffer write pointer: increments per written pixel, wraps after the last
// pixel of a frame, and clears on ALIGN or buffer swap.
`timescale 1ns/1ps

module fb_addr_gen #(
    parameter int DEPTH      = 76800,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc,
    input  logic                  clr,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  wrap
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    // wrap flags the increment that consumes the last address of the frame
    assign wrap = inc && (addr == LAST_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (clr) begin
            addr <= '0;
        end else if (inc) begin
            if (wrap)
                addr <= '0;
            else
                addr <= addr + 1'b1;
        end
    end

endmodule

// File: rtl/fb_swap_ctrl.sv
// Decodes an SPI byte stream into framebuffer pixel writes and double-buffer swaps.
// Define FB_DROP_COUNT_EN to implement the saturating dropped-pixel counter.
`timescale 1ns/1ps

module fb_swap_ctrl
    import fb_pkg::*;
#(
    parameter  int RES_X      = 320,
    parameter  int RES_Y      = 240,
    localparam int ADDR_WIDTH = $clog2(RES_X * RES_Y)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    input  logic                  vblank_start,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [PIXEL_W-1:0]    wr_data,
    output logic                  wr_buf,
    output logic                  rd_buf,
    output logic                  swap_pending,
    output logic                  frame_wrap,
    output logic [7:0]            drop_count
);

    // state     | meaning
    // STREAM    | pixel bytes written to the back buffer at the current pointer
    // SWAP_WAIT | swap requested; pixels dropped until vblank_start flips buffers

    fb_state_t             state;
    byte_kind_t            kind;
    logic                  is_pixel;
    logic                  is_align;
    logic                  is_swap;
    logic                  swap_now;
    logic                  ptr_inc;
    logic                  ptr_clr;
    logic                  ptr_wrap;
    logic [ADDR_WIDTH-1:0] ptr;

    assign kind     = decode_byte(byte_data);
    assign is_pixel = byte_valid && (kind == BYTE_PIXEL);
    assign is_align = byte_valid && (kind == BYTE_ALIGN);
    assign is_swap  = byte_valid && (kind == BYTE_SWAP);

    // A byte coinciding with the swapping vblank is still handled as SWAP_WAIT.
    assign swap_now = (state == SWAP_WAIT) && vblank_start;
    assign ptr_inc  = (state == STREAM) && is_pixel;
    assign ptr_clr  = is_align || swap_now;

    fb_addr_gen #(
        .DEPTH      (RES_X * RES_Y),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ptr_inc),
        .clr   (ptr_clr),
        .addr  (ptr),
        .wrap  (ptr_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= STREAM;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            wr_buf       <= 1'b1;
            swap_pending <= 1'b0;
            frame_wrap   <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_wrap <= 1'b0;
            case (state)
                STREAM: begin
                    if (is_pixel) begin
                        wr_en      <= 1'b1;
                        wr_addr    <= ptr;
                        wr_data    <= byte_data[PIXEL_W-1:0];
                        frame_wrap <= ptr_wrap;
                    end else if (is_swap) begin
                        state        <= SWAP_WAIT;
                        swap_pending <= 1'b1;
                    end
                end
                SWAP_WAIT: begin
                    if (vblank_start) begin
                        state        <= STREAM;
                        swap_pending <= 1'b0;
                        wr_buf       <= ~wr_buf;
                    end
                end
            endcase
        end
    end

    assign rd_buf = ~wr_buf;

`ifdef FB_DROP_COUNT_EN
    logic [7:0] drop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_q <= 8'd0;
        else if ((state == SWAP_WAIT) && is_pixel && (drop_q != 8'hFF))
            drop_q <= drop_q + 8'd1;
    end

    assign drop_count = drop_q;
`else
    assign drop_count = 8'd0;
`endif

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Directed self-checking bench for fb_swap_ctrl at the default 320x240 resolution.
`timescale 1ns/1ps

module tb_fb_swap_ctrl;
    import fb_pkg::*;

    localparam int RES_X      = 320;
    localparam int RES_Y      = 240;
    localparam int NPIX       = RES_X * RES_Y;
    localparam int ADDR_WIDTH = 17;
`ifdef FB_DROP_COUNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  byte_valid = 1'b0;
    logic [7:0]            byte_data = 8'h00;
    logic                  vblank_start = 1'b0;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [PIXEL_W-1:0]    wr_data;
    logic                  wr_buf;
    logic                  rd_buf;
    logic                  swap_pending;
    logic                  frame_wrap;
    logic [7:0]            drop_count;

    int checks = 0;
    int errors = 0;

    fb_swap_ctrl #(.RES_X(RES_X), .RES_Y(RES_Y)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .vblank_start (vblank_start),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_buf       (wr_buf),
        .rd_buf       (rd_buf),
        .swap_pending (swap_pending),
        .frame_wrap   (frame_wrap),
        .drop_count   (drop_count)
    );

    always #10 clk = ~clk;

    function automatic logic [7:0] exp_drop(input int n);
        if (!DROP_EN) return 8'd0;
        return (n > 255) ? 8'd255 : 8'(n);
    endfunction

    // Present one byte for one cycle; outputs are valid on return.
    task automatic send(input logic [7:0] b, input logic vb);
        @(negedge clk);
        byte_valid   = 1'b1;
        byte_data    = b;
        vblank_start = vb;
        @(negedge clk);
        byte_valid   = 1'b0;
        vblank_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %0h exp 0", wr_en); end
        checks++; if (wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr got %0h exp 0", wr_addr); end
        checks++; if (wr_data !== '0) begin errors++; $display("FAIL reset_wr_data got %0h exp 0", wr_data); end
        checks++; if (wr_buf !== 1'b1 || rd_buf !== 1'b0) begin errors++; $display("FAIL reset_bufs got wr=%0h rd=%0h exp wr=1 rd=0", wr_buf, rd_buf); end
        checks++; if (swap_pending !== 1'b0 || frame_wrap !== 1'b0) begin errors++; $display("FAIL reset_flags got sp=%0h fw=%0h exp 0 0", swap_pending, frame_wrap); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d exp 0", drop_count); end
        rst_n = 1'b1;
    endtask

    task automatic test_align_pixel();
        send(CMD_ALIGN, 1'b0);
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL align_no_write got %0h exp 0", wr_en); end
        send(8'h1B, 1'b0);
        checks++; if (wr_en !== 1'b1 || wr_addr !== 17'd0 || wr_data !== 6'h1B) begin errors++; $display("FAIL first_pixel got en=%0h addr=%0d data=%0h exp en=1 addr=0 data=1b", wr_en, wr_addr, wr_data); end
        @(negedge clk);
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL wr_en_one_cycle got %0h exp 0", wr_en); end
    endtask

    task automatic test_sequence();
        logic [7:0] pix [3];
        pix[0] = 8'h1B; pix[1] = 8'h3F; pix[2] = 8'h2A;
        send(CMD_ALIGN, 1'b0);
        for (int i = 0; i < 3; i++) begin
            send(pix[i], 1'b0);
            checks++; if (wr_en !== 1'b1 || wr_addr !== 17'(i) || wr_data !== pix[i][5:0]) begin errors++; $display("FAIL seq_pixel%0d got en=%0h addr=%0d data=%0h exp en=1 addr=%0d data=%0h", i, wr_en, wr_addr, wr_data, i, pix[i][5:0]); end
        end
        send(CMD_ALIGN, 1'b0);
        send(8'h00, 1'b0);
        checks++; if (wr_en !== 1'b1 || wr_addr !== 17'd0 || wr_data !== 6'h00) begin errors++; $display("FAIL realign got en=%0h addr=%0d data=%0h exp en=1 addr=0 data=0", wr_en, wr_addr, wr_data); end
        send(8'h7F, 1'b0);
        checks++; if (wr_en !== 1'b1 || wr_addr !== 17'd1 || wr_data !== 6'h3F) begin errors++; $display("FAIL bit6_ignored got en=%0h addr=%0d data=%0h exp en=1 addr=1 data=3f", wr_en, wr_addr, wr_data); end
        send(8'hC5, 1'b0);
        checks++; if (wr_en !== 1'b0 || swap_pending !== 1'b0) begin errors++; $display("FAIL other_cmd got en=%0h sp=%0h exp 0 0", wr_en, swap_pending); end
        send(8'h12, 1'b0);
        checks++; if (wr_en !== 1'b1 || wr_addr !== 17'd2) begin errors++; $display("FAIL after_other got en=%0h addr=%0d exp en=1 addr=2", wr_en, wr_addr); end
    endtask

    task automatic test_vblank_stream();
        @(negedge clk);
        vblank_start = 1'b1;
        @(negedge clk);
        vblank_start = 1'b0;
        checks++; if (wr_buf !== 1'b1 || swap_pending !== 1'b0 || wr_en !== 1'b0) begin errors++; $display("FAIL vblank_stream got wr_buf=%0h sp=%0h en=%0h exp 1 0 0", wr_buf, swap_pending, wr_en); end
        send(8'h05, 1'b0);
        checks++; if (wr_en !== 1'b1 || wr_addr !== 17'd3) begin errors++; $display("FAIL vblank_stream_ptr got en=%0h addr=%0d exp en=1 addr=3", wr_en, wr_addr); end
    endtask

    task automatic test_frame_wrap();
        int wraps = 0;
        int bad = 0;
        logic [ADDR_WIDTH-1:0] wrap_at = '0;
        logic [ADDR_WIDTH-1:0] last = '0;
        send(CMD_ALIGN, 1'b0);
        for (int k = 0; k <= NPIX; k++) begin
            @(negedge clk);
            if (k > 0) begin
                if (wr_en !== 1'b1 || wr_addr !== ADDR_WIDTH'(k - 1)) bad++;
                if (frame_wrap === 1'b1) begin wraps++; wrap_at = wr_addr; end
                last = wr_addr;
            end
            if (k < NPIX) begin
                byte_valid = 1'b1;
                byte_data  = 8'(k & 63);
            end else begin
                byte_valid = 1'b0;
            end
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL frame_addr_seq got %0d bad writes exp 0", bad); end
        checks++; if (wraps != 1 || wrap_at !== 17'd76799) begin errors++; $display("FAIL frame_wrap_pulse got count=%0d at=%0d exp count=1 at=76799", wraps, wrap_at); end
        checks++; if (last !== 17'd76799) begin errors++; $display("FAIL frame_last_addr got %0d exp 76799", last); end
        send(8'h15, 1'b0);
        checks++; if (wr_en !== 1'b1 || wr_addr !== 17'd0 || frame_wrap !== 1'b0) begin errors++; $display("FAIL after_wrap got en=%0h addr=%0d fw=%0h exp en=1 addr=0 fw=0", wr_en, wr_addr, frame_wrap); end
    endtask

    task automatic test_swap();
        send(CMD_SWAP, 1'b0);
        checks++; if (swap_pending !== 1'b1 || wr_en !== 1'b0) begin errors++; $display("FAIL swap_enter got sp=%0h en=%0h exp 1 0", swap_pending, wr_en); end
        for (int i = 0; i < 3; i++) begin
            send(8'h20 + 8'(i), 1'b0);
            checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL drop_no_write%0d got %0h exp 0", i, wr_en); end
        end
        checks++; if (drop_count !== exp_drop(3) || wr_buf !== 1'b1 || rd_buf !== 1'b0 || swap_pending !== 1'b1) begin errors++; $display("FAIL swap_wait got drop=%0d wr=%0h rd=%0h sp=%0h exp drop=%0d wr=1 rd=0 sp=1", drop_count, wr_buf, rd_buf, swap_pending, exp_drop(3)); end
        send(CMD_SWAP, 1'b0);
        checks++; if (swap_pending !== 1'b1 || wr_buf !== 1'b1 || drop_count !== exp_drop(3)) begin errors++; $display("FAIL repeat_swap got sp=%0h wr=%0h drop=%0d exp sp=1 wr=1 drop=%0d", swap_pending, wr_buf, drop_count, exp_drop(3)); end
        send(8'h11, 1'b1);
        checks++; if (wr_en !== 1'b0 || wr_buf !== 1'b0 || rd_buf !== 1'b1 || swap_pending !== 1'b0 || drop_count !== exp_drop(4)) begin errors++; $display("FAIL swap_vblank got en=%0h wr=%0h rd=%0h sp=%0h drop=%0d exp en=0 wr=0 rd=1 sp=0 drop=%0d", wr_en, wr_buf, rd_buf, swap_pending, drop_count, exp_drop(4)); end
        send(8'h2C, 1'b0);
        checks++; if (wr_en !== 1'b1 || wr_addr !== 17'd0 || wr_data !== 6'h2C) begin errors++; $display("FAIL post_swap_pixel got en=%0h addr=%0d data=%0h exp en=1 addr=0 data=2c", wr_en, wr_addr, wr_data); end
    endtask

    task automatic test_saturate_and_reset();
        int writes = 0;
        send(CMD_SWAP, 1'b0);
        for (int k = 0; k <= 300; k++) begin
            @(negedge clk);
            if (wr_en === 1'b1) writes++;
            byte_valid = (k < 300);
            byte_data  = 8'h0A;
        end
        checks++; if (writes != 0 || drop_count !== exp_drop(304) || swap_pending !== 1'b1) begin errors++; $display("FAIL drop_saturate got writes=%0d drop=%0d sp=%0h exp writes=0 drop=%0d sp=1", writes, drop_count, swap_pending, exp_drop(304)); end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (wr_buf !== 1'b1 || rd_buf !== 1'b0 || swap_pending !== 1'b0 || drop_count !== 8'd0) begin errors++; $display("FAIL reset_mid_wait got wr=%0h rd=%0h sp=%0h drop=%0d exp wr=1 rd=0 sp=0 drop=0", wr_buf, rd_buf, swap_pending, drop_count); end
        rst_n = 1'b1;
        @(negedge clk);
        vblank_start = 1'b1;
        @(negedge clk);
        vblank_start = 1'b0;
        checks++; if (wr_buf !== 1'b1 || swap_pending !== 1'b0) begin errors++; $display("FAIL swap_cancelled got wr=%0h sp=%0h exp wr=1 sp=0", wr_buf, swap_pending); end
        send(8'h33, 1'b0);
        checks++; if (wr_en !== 1'b1 || wr_addr !== 17'd0 || wr_data !== 6'h33) begin errors++; $display("FAIL post_reset_pixel got en=%0h addr=%0d data=%0h exp en=1 addr=0 data=33", wr_en, wr_addr, wr_data); end
    endtask

    initial begin
        test_reset();
        test_align_pixel();
        test_sequence();
        test_vblank_stream();
        test_frame_wrap();
        test_swap();
        test_saturate_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
